// File: rtl/alu_op_sequencer.sv
// ALU operand/select initiator: drives ALU_8bit, waits a settle time,
// captures the result and returns it with an accumulator and op counter.
module alu_op_sequencer #(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic [3:0]       cmd_sel,
  input  logic             cmd_use_acc,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [3:0]       alu_sel,
  input  logic [7:0]       alu_out,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_result,
  output logic             rsp_carry,
  output logic             rsp_err,
  output logic [7:0]       acc,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] SEL_MAX  = 4'b1001;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic       err;
  logic       accept;
  logic       sample;
  logic       rsp_hs;

  assign accept = (state == IDLE) && cmd_valid;
  assign sample = (state == DRIVE) && (cnt == 4'd0);
  assign rsp_hs = (state == RESP) && rsp_valid && rsp_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    unique case (1'b1)
      state == IDLE:  if (cmd_valid) state_nxt = DRIVE;
      state == DRIVE: if (cnt == 4'd0) state_nxt = RESP;
      state == RESP:  if (rsp_ready) state_nxt = IDLE;
      default:        state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    cmd_ready = (state == IDLE);
  end

  // Operand launch, settle count, capture, accumulator and op counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= 4'd0;
      err        <= 1'b0;
      alu_a      <= 8'h00;
      alu_b      <= 8'h00;
      alu_sel    <= 4'h0;
      rsp_valid  <= 1'b0;
      rsp_result <= 8'h00;
      rsp_carry  <= 1'b0;
      rsp_err    <= 1'b0;
      acc        <= 8'h00;
      op_count   <= '0;
    end else begin
      if (accept) begin
        alu_a   <= cmd_use_acc ? acc : cmd_a;
        alu_b   <= cmd_b;
        alu_sel <= cmd_sel;
        err     <= (cmd_sel > SEL_MAX);
        cnt     <= CNT_INIT;
      end
      if (state == DRIVE && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (sample) begin
        rsp_valid  <= 1'b1;
        rsp_err    <= err;
        rsp_result <= err ? 8'h00 : alu_out;
        rsp_carry  <= err ? 1'b0 : alu_carry;
        if (!err) begin
          acc <= alu_out;
        end
      end
      if (rsp_hs) begin
        rsp_valid <= 1'b0;
        if (op_count != '1) begin
          op_count <= op_count + CNT_ONE;
        end
      end
    end
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Initiator side of the 8-bit ALU operand/select interface.
- Accepts ALU commands over a valid/ready command channel and drives A, B and ALU_Sel into the combinational ALU_8bit.
- Holds the operands for a programmable settle time, then captures ALU_Out/CarryOut and returns them on a valid/ready response channel.
- Keeps an accumulator so results can be chained, and counts completed operations.

Parameters:
- SETTLE_CYCLES, 1, cycles alu_* are held stable before sampling; legal range 1..15, 0 illegal.
- CNT_W, 16, width of op_count.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  sequencer can accept a command.
- cmd_a  input  8  operand A.
- cmd_b  input  8  operand B.
- cmd_sel  input  4  ALU select code, 0000..1001 legal.
- cmd_use_acc  input  1  1: use accumulator instead of cmd_a as A.
- alu_a  output  8  to ALU_8bit.A.
- alu_b  output  8  to ALU_8bit.B.
- alu_sel  output  4  to ALU_8bit.ALU_Sel.
- alu_out  input  8  from ALU_8bit.ALU_Out.
- alu_carry  input  1  from ALU_8bit.CarryOut.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_result  output  8  captured result.
- rsp_carry  output  1  captured carry.
- rsp_err  output  1  command had an illegal select code.
- acc  output  8  accumulator (last legal result).
- op_count  output  CNT_W  completed response handshakes.

Behaviour:
- Reset (rst_n low, takes effect immediately, asynchronous): all outputs 0 except cmd_ready; FSM goes to IDLE; settle counter 0. cmd_ready is 1 once in IDLE. Any in-flight command is dropped and no response is produced for it.
- FSM states: IDLE, DRIVE, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready at edge E0, register alu_a = cmd_use_acc ? acc : cmd_a, alu_b = cmd_b, alu_sel = cmd_sel.
  - Latch err = (cmd_sel > 4'b1001).
  - Load settle counter with SETTLE_CYCLES-1 and go to DRIVE.
- DRIVE:
  - cmd_ready=0.
  - At each edge, if counter==0: rsp_result<=alu_out, rsp_carry<=alu_carry, rsp_err<=err, rsp_valid<=1, go to RESP. Otherwise decrement the counter.
  - If err=1, rsp_result<=0x00 and rsp_carry<=0 instead of the ALU values.
  - rsp_valid therefore rises at edge E0+SETTLE_CYCLES.
- RESP:
  - cmd_ready=0, rsp_* held stable.
  - On rsp_valid&rsp_ready: rsp_valid<=0, go to IDLE.
  - The next command can be accepted no earlier than the cycle after the response handshake, so throughput is one op per SETTLE_CYCLES+2 cycles.
- alu_a/alu_b/alu_sel hold their last driven values in IDLE and RESP and change only on command accept.
- acc updates to the captured alu_out at the DRIVE→RESP edge, only when err=0. It is unchanged on illegal commands.
- op_count increments on each response handshake, error responses included, and saturates at all-ones with no wrap.
- A command presented while in DRIVE or RESP is not accepted (cmd_ready=0). It must be held by the source.
- cmd_* inputs are ignored outside the accept edge.
- rsp_ready asserted while rsp_valid=0 has no effect.
- Reset asserted in DRIVE or RESP: rsp_valid drops immediately, acc clears to 0, op_count clears to 0.

Test Plan:
- SETTLE_CYCLES=1 with ALU_8bit attached: cmd A=0x0A, B=0x02, sel=0000, rsp_ready=1 → cmd_ready low one cycle after accept; rsp_valid one cycle after accept; rsp_result=0x0C, rsp_carry=0; acc=0x0C; op_count=1.
- Chained ops: ADD 0xFF+0x01 → result 0x00, carry=1. Then cmd_use_acc=1, B=0x0F, sel=0011 (OR) → alu_a=0x00, result 0x0F. Then use_acc, B=0x03, sel=0010 (AND) → result 0x03; op_count=3.
- Illegal select: sel=1100, A=0x55, B=0xAA → rsp_err=1, rsp_result=0x00, rsp_carry=0; acc unchanged; op_count increments.
- Backpressure: hold rsp_ready=0 for 5 cycles after rsp_valid → rsp_* stable, cmd_ready=0 throughout, second cmd_valid not accepted. Release rsp_ready → handshake, then the second command is accepted one cycle later.
- SETTLE_CYCLES=4: SUB A=0x0A, B=0x02 → alu_* stable for 4 cycles, rsp_valid rises exactly 4 edges after accept, rsp_result=0x08.
- Reset mid-operation: assert rst_n=0 asynchronously in DRIVE → rsp_valid, alu_*, acc and op_count read 0 before the next clock edge. After release, cmd_ready=1 and no stale response appears.
